core_ctrl: RTL and testbench

- Multi-cycle control FSM for the 16-bit core. Sequences fetch, decode, execute, memory and writeback around the shared instruction register, ALU, register file and single-port memories.
- Consumes the decoder's op/func/rd fields plus branch-compare and memory-ready status.
- Produces all datapath enables, mux selects and memory request strobes.
- Bounds every memory wait with a timeout.

---
 rtl/core_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/writeback control FSM for the 16-bit core.
// Optional illegal-opcode trap enabled by defining CORE_CTRL_ILLEGAL_TRAP_EN.
module core_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] op_i,
  input  logic [2:0] func2_i,
  input  logic [3:0] func4_i,
  input  logic [2:0] rd_i,
  input  logic       branch_taken_i,
  input  logic       imem_ready_i,
  input  logic       dmem_ready_i,
  output logic       imem_req_o,
  output logic       ir_we_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       alu_src_imm_o,
  output logic [3:0] alu_op_o,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       bus_err_o,
  output logic       trap_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] OP_R = 3'b000;
  localparam logic [2:0] OP_I = 3'b001;
  localparam logic [2:0] OP_L = 3'b010;
  localparam logic [2:0] OP_S = 3'b011;
  localparam logic [2:0] OP_B = 3'b100;
  localparam logic [2:0] OP_J = 3'b101;

  // Last count value at which a still-missing ready becomes a timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  logic             w_wait;
  logic             w_timeout;
  logic             w_imem_req;
  logic             w_ir_we;
  logic             w_dmem_req;
  logic             w_dmem_we;
  logic             w_alu_src_imm;
  logic [3:0]       w_alu_op;
  logic             w_rf_we;
  logic [1:0]       w_wb_sel;
  logic             w_pc_we;
  logic [1:0]       w_pc_sel;
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
  logic             r_trap;
  logic             w_set_trap;
`endif

  // Next-state and datapath control decode.
  always_comb begin
    w_next        = r_state;
    w_wait        = 1'b0;
    w_timeout     = 1'b0;
    w_imem_req    = 1'b0;
    w_ir_we       = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_alu_src_imm = 1'b0;
    w_alu_op      = 4'b0000;
    w_rf_we       = 1'b0;
    w_wb_sel      = 2'b00;
    w_pc_we       = 1'b0;
    w_pc_sel      = 2'b00;
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
    w_set_trap    = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready_i) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end else begin
          w_wait = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_timeout = 1'b1;
            w_next    = S_HALT;
          end
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        case (op_i)
          OP_R: begin
            w_alu_op = func4_i;
            w_next   = S_WB;
          end
          OP_I: begin
            w_alu_op      = {1'b1, func2_i};
            w_alu_src_imm = 1'b1;
            w_next        = S_WB;
          end
          OP_L, OP_S: begin
            w_alu_src_imm = 1'b1;
            w_next        = S_MEM;
          end
          OP_B: begin
            w_alu_op = 4'b0001;
            w_pc_we  = 1'b1;
            w_pc_sel = branch_taken_i ? 2'b01 : 2'b00;
            w_next   = S_FETCH;
          end
          OP_J: w_next = S_WB;
          default: begin
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
            w_set_trap = 1'b1;
            w_next     = S_TRAP;
`else
            w_pc_we = 1'b1;
            w_next  = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        w_dmem_req    = 1'b1;
        w_dmem_we     = (op_i == OP_S);
        w_alu_src_imm = 1'b1;
        if (dmem_ready_i) begin
          if (op_i == OP_S) begin
            w_pc_we = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else begin
          w_wait = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_timeout = 1'b1;
            w_next    = S_HALT;
          end
        end
      end
      S_WB: begin
        w_rf_we = (rd_i != 3'b000);
        w_pc_we = 1'b1;
        if (op_i == OP_L) begin
          w_wb_sel = 2'b01;
        end else if (op_i == OP_J) begin
          w_wb_sel = 2'b10;
          w_pc_sel = 2'b10;
        end
        w_next = S_FETCH;
      end
      S_HALT, S_TRAP: w_next = r_state;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait counter restarts on every state change; timeout flag is sticky.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (w_wait) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_trap <= 1'b0;
    end else if (w_set_trap) begin
      r_trap <= 1'b1;
    end
  end
  assign trap_o = r_trap & ~rst_i;
`else
  assign trap_o = 1'b0;
`endif

  // Reset forces every output low at once so an in-flight access drops.
  assign imem_req_o    = w_imem_req    & ~rst_i;
  assign ir_we_o       = w_ir_we       & ~rst_i;
  assign dmem_req_o    = w_dmem_req    & ~rst_i;
  assign dmem_we_o     = w_dmem_we     & ~rst_i;
  assign alu_src_imm_o = w_alu_src_imm & ~rst_i;
  assign alu_op_o      = rst_i ? 4'b0000 : w_alu_op;
  assign rf_we_o       = w_rf_we       & ~rst_i;
  assign wb_sel_o      = rst_i ? 2'b00 : w_wb_sel;
  assign pc_we_o       = w_pc_we       & ~rst_i;
  assign pc_sel_o      = rst_i ? 2'b00 : w_pc_sel;
  assign bus_err_o     = r_bus_err     & ~rst_i;
  assign state_o       = rst_i ? 3'b000 : r_state;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed self-checking bench for core_ctrl; follows CORE_CTRL_ILLEGAL_TRAP_EN if defined.
module tb_core_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] op = 3'b000;
  logic [2:0] func2 = 3'b000;
  logic [3:0] func4 = 4'b0000;
  logic [2:0] rd = 3'b000;
  logic       bt = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;

  logic       imem_req, ir_we, dmem_req, dmem_we, alu_src_imm, rf_we, pc_we, bus_err, trap;
  logic [3:0] alu_op;
  logic [1:0] wb_sel, pc_sel;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  core_ctrl dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .func2_i(func2), .func4_i(func4), .rd_i(rd),
    .branch_taken_i(bt), .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
    .imem_req_o(imem_req), .ir_we_o(ir_we), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .alu_src_imm_o(alu_src_imm), .alu_op_o(alu_op), .rf_we_o(rf_we), .wb_sel_o(wb_sel),
    .pc_we_o(pc_we), .pc_sel_o(pc_sel), .bus_err_o(bus_err), .trap_o(trap), .state_o(state)
  );

  always #5 clk = ~clk;

  // Output vector: {state, imem_req, ir_we, dmem_req, dmem_we, imm, alu_op, rf_we, wb_sel, pc_we, pc_sel, bus_err, trap}
  function automatic logic [19:0] mk(input logic [2:0] st, input logic ireq, input logic irwe,
                                     input logic dreq, input logic dwe, input logic imm,
                                     input logic [3:0] aop, input logic rfwe, input logic [1:0] wbs,
                                     input logic pcwe, input logic [1:0] pcs, input logic berr,
                                     input logic trp);
    return {st, ireq, irwe, dreq, dwe, imm, aop, rfwe, wbs, pcwe, pcs, berr, trp};
  endfunction

  function automatic logic [19:0] obs();
    return {state, imem_req, ir_we, dmem_req, dmem_we, alu_src_imm, alu_op, rf_we, wb_sel,
            pc_we, pc_sel, bus_err, trap};
  endfunction

  // Leaves the bench at a negedge with the DUT freshly in FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; bt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; op = 3'b011; rd = 3'd5; bt = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (obs() !== 20'h0) begin
      failures++; $display("FAIL reset_hold got=%05h exp=%05h", obs(), 20'h0);
    end
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; #1;
    checks++;
    if (obs() !== mk(3'd0,1,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0)) begin
      failures++; $display("FAIL reset_state got=%05h exp=%05h", obs(), mk(3'd0,1,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0));
    end
  endtask

  task automatic test_rtype_itype();
    logic [19:0] e [10];
    do_reset();
    op = 3'b000; func4 = 4'b0101; func2 = 3'b110; rd = 3'd3; imem_ready = 1'b1;
    e[0] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[1] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[2] = mk(3'd2,0,0,0,0,0,4'h5,0,2'b00,0,2'b00,0,0);
    e[3] = mk(3'd4,0,0,0,0,0,4'h0,1,2'b00,1,2'b00,0,0);
    e[4] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[5] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[6] = mk(3'd2,0,0,0,0,1,4'hE,0,2'b00,0,2'b00,0,0);
    e[7] = mk(3'd4,0,0,0,0,0,4'h0,1,2'b00,1,2'b00,0,0);
    e[8] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[9] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin op = 3'b001; rd = 3'd1; end
      #1;
      checks++;
      if (obs() !== e[i]) begin
        failures++; $display("FAIL rtype_itype cyc%0d got=%05h exp=%05h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_store();
    logic [19:0] e [14];
    do_reset();
    op = 3'b010; rd = 3'd2; imem_ready = 1'b1;
    e[0]  = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[1]  = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[2]  = mk(3'd2,0,0,0,0,1,4'h0,0,2'b00,0,2'b00,0,0);
    e[3]  = mk(3'd3,0,0,1,0,1,4'h0,0,2'b00,0,2'b00,0,0);
    e[4]  = e[3];
    e[5]  = e[3];
    e[6]  = e[3];
    e[7]  = mk(3'd4,0,0,0,0,0,4'h0,1,2'b01,1,2'b00,0,0);
    e[8]  = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[9]  = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[10] = mk(3'd2,0,0,0,0,1,4'h0,0,2'b00,0,2'b00,0,0);
    e[11] = mk(3'd3,0,0,1,1,1,4'h0,0,2'b00,1,2'b00,0,0);
    e[12] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[13] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    for (int i = 0; i < 14; i++) begin
      // dmem_ready high in FETCH/DECODE/EXEC must be ignored
      dmem_ready = (i <= 2) || (i == 6) || (i == 11);
      if (i == 8) begin op = 3'b011; rd = 3'd5; end
      #1;
      checks++;
      if (obs() !== e[i]) begin
        failures++; $display("FAIL load_store cyc%0d got=%05h exp=%05h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_branch();
    logic [19:0] e [7];
    do_reset();
    op = 3'b100; rd = 3'd6; imem_ready = 1'b1; bt = 1'b1;
    e[0] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[1] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[2] = mk(3'd2,0,0,0,0,0,4'h1,0,2'b00,1,2'b01,0,0);
    e[3] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[4] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[5] = mk(3'd2,0,0,0,0,0,4'h1,0,2'b00,1,2'b00,0,0);
    e[6] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) bt = 1'b0;
      #1;
      checks++;
      if (obs() !== e[i]) begin
        failures++; $display("FAIL branch cyc%0d got=%05h exp=%05h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jump();
    logic [19:0] e [9];
    do_reset();
    op = 3'b101; rd = 3'd0; imem_ready = 1'b1;
    e[0] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[1] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[2] = mk(3'd2,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[3] = mk(3'd4,0,0,0,0,0,4'h0,0,2'b10,1,2'b10,0,0);
    e[4] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[5] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[6] = mk(3'd2,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[7] = mk(3'd4,0,0,0,0,0,4'h0,1,2'b10,1,2'b10,0,0);
    e[8] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) rd = 3'd7;
      #1;
      checks++;
      if (obs() !== e[i]) begin
        failures++; $display("FAIL jump cyc%0d got=%05h exp=%05h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_imem_timeout();
    logic [19:0] exp_v;
    do_reset();
    op = 3'b000; imem_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) imem_ready = 1'b1;
      exp_v = (i < 15) ? mk(3'd0,1,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0)
                       : mk(3'd5,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,1,0);
      #1;
      checks++;
      if (obs() !== exp_v) begin
        failures++; $display("FAIL imem_timeout cyc%0d got=%05h exp=%05h", i, obs(), exp_v);
      end
      @(negedge clk);
    end
    rst = 1'b1; #1;
    checks++;
    if (obs() !== 20'h0) begin
      failures++; $display("FAIL halt_reset got=%05h exp=%05h", obs(), 20'h0);
    end
  endtask

  task automatic test_ready_at_limit();
    logic [19:0] exp_v;
    do_reset();
    op = 3'b000; imem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      imem_ready = (i >= 14);
      if (i < 14)       exp_v = mk(3'd0,1,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
      else if (i == 14) exp_v = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
      else              exp_v = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
      #1;
      checks++;
      if (obs() !== exp_v) begin
        failures++; $display("FAIL ready_at_limit cyc%0d got=%05h exp=%05h", i, obs(), exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_dmem_timeout();
    logic [19:0] exp_v;
    do_reset();
    op = 3'b011; rd = 3'd1; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp_v = (i < 15) ? mk(3'd3,0,0,1,1,1,4'h0,0,2'b00,0,2'b00,0,0)
                       : mk(3'd5,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,1,0);
      #1;
      checks++;
      if (obs() !== exp_v) begin
        failures++; $display("FAIL dmem_timeout cyc%0d got=%05h exp=%05h", i, obs(), exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_op();
    logic [19:0] e [5];
    do_reset();
    op = 3'b111; rd = 3'd4; imem_ready = 1'b1;
    e[0] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[1] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
    e[2] = mk(3'd2,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[3] = mk(3'd6,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,1);
    e[4] = e[3];
`else
    e[2] = mk(3'd2,0,0,0,0,0,4'h0,0,2'b00,1,2'b00,0,0);
    e[3] = mk(3'd0,1,1,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    e[4] = mk(3'd1,0,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
`endif
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs() !== e[i]) begin
        failures++; $display("FAIL illegal_op cyc%0d got=%05h exp=%05h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [19:0] e [3];
    do_reset();
    op = 3'b011; rd = 3'd2; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    e[0] = mk(3'd3,0,0,1,1,1,4'h0,0,2'b00,0,2'b00,0,0);
    e[1] = 20'h0;
    e[2] = mk(3'd0,1,0,0,0,0,4'h0,0,2'b00,0,2'b00,0,0);
    for (int i = 0; i < 3; i++) begin
      rst = (i == 1);
      dmem_ready = (i == 1);
      #1;
      checks++;
      if (obs() !== e[i]) begin
        failures++; $display("FAIL reset_mid_mem cyc%0d got=%05h exp=%05h", i, obs(), e[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rtype_itype();
    test_load_store();
    test_branch();
    test_jump();
    test_imem_timeout();
    test_ready_at_limit();
    test_dmem_timeout();
    test_illegal_op();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
